// File: rtl/ibex_pkg.sv
// Shared types for the register-file wipe sequencer.
package ibex_pkg;

    typedef enum logic [1:0] {
        WIPE_IDLE   = 2'd0,
        WIPE_WRITE  = 2'd1,
        WIPE_VERIFY = 2'd2,
        WIPE_DONE   = 2'd3
    } rf_wipe_state_e;

endpackage

// File: rtl/ibex_rf_wipe_ctrl.sv
// Register-file wipe sequencer: passes core writes through when idle, otherwise walks the
// write port over every register. Optional readback pass enabled by IBEX_RF_WIPE_VERIFY_EN.
module ibex_rf_wipe_ctrl
    import ibex_pkg::*;
#(
    parameter bit                   RV32E             = 1'b0,
    parameter int unsigned          DataWidth         = 32,
    parameter bit                   DummyInstructions = 1'b0,
    parameter logic [DataWidth-1:0] WipeVal           = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wipe_req_i,
    output logic                 wipe_ack_o,
    output logic                 wipe_busy_o,
    output logic                 wipe_done_o,
    output logic                 core_stall_o,
    input  logic                 core_we_i,
    input  logic [4:0]           core_waddr_i,
    input  logic [DataWidth-1:0] core_wdata_i,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_dummy_wb_o,
    output logic [4:0]           rf_raddr_o,
    input  logic [DataWidth-1:0] rf_rdata_i,
    output logic                 verify_err_o
);

    localparam int unsigned NumWords  = RV32E ? 16 : 32;
    localparam logic [4:0]  FirstAddr = DummyInstructions ? 5'd0 : 5'd1;
    localparam logic [4:0]  LastAddr  = 5'(NumWords - 1);

    rf_wipe_state_e state_q;
    logic [4:0]     cnt_q;
    logic           busy_q;
    logic           done_q;
`ifdef IBEX_RF_WIPE_VERIFY_EN
    logic           err_q;
    logic           rd_mismatch;

    assign rd_mismatch = (state_q == WIPE_VERIFY) && (rf_rdata_i != WipeVal);
`endif

    // Handshake: wipe_req_i is a level; it is taken in any IDLE cycle where it is high,
    // and wipe_ack_o marks exactly that cycle. Requests in any other state are ignored.
    assign wipe_ack_o = (state_q == WIPE_IDLE) && wipe_req_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= WIPE_IDLE;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef IBEX_RF_WIPE_VERIFY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                WIPE_IDLE: begin
                    if (wipe_req_i) begin
                        state_q <= WIPE_WRITE;
                        cnt_q   <= FirstAddr;
                        busy_q  <= 1'b1;
`ifdef IBEX_RF_WIPE_VERIFY_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                WIPE_WRITE: begin
                    if (cnt_q == LastAddr) begin
`ifdef IBEX_RF_WIPE_VERIFY_EN
                        // R0 is never checked, so the readback pass always starts at 1.
                        state_q <= WIPE_VERIFY;
                        cnt_q   <= 5'd1;
`else
                        state_q <= WIPE_DONE;
                        cnt_q   <= 5'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
`ifdef IBEX_RF_WIPE_VERIFY_EN
                WIPE_VERIFY: begin
                    if (rd_mismatch) begin
                        err_q <= 1'b1;
                    end
                    if (cnt_q == LastAddr) begin
                        state_q <= WIPE_DONE;
                        cnt_q   <= 5'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
`endif
                WIPE_DONE: begin
                    state_q <= WIPE_IDLE;
                end
                default: begin
                    state_q <= WIPE_IDLE;
                    cnt_q   <= 5'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wipe_busy_o  = busy_q;
    assign core_stall_o = busy_q;
    assign wipe_done_o  = done_q;

    // Core writes are dropped while busy; DONE already hands the port back.
    always_comb begin
        rf_we_o       = core_we_i;
        rf_waddr_o    = core_waddr_i;
        rf_wdata_o    = core_wdata_i;
        rf_dummy_wb_o = 1'b0;
        if (state_q == WIPE_WRITE) begin
            rf_we_o       = 1'b1;
            rf_waddr_o    = cnt_q;
            rf_wdata_o    = WipeVal;
            rf_dummy_wb_o = (cnt_q == 5'd0);
        end else if (state_q == WIPE_VERIFY) begin
            rf_we_o = 1'b0;
        end
    end

`ifdef IBEX_RF_WIPE_VERIFY_EN
    assign rf_raddr_o   = (state_q == WIPE_VERIFY) ? cnt_q : 5'd0;
    // The flag rises in the very cycle the bad word is read, then holds.
    assign verify_err_o = err_q | rd_mismatch;
`else
    logic unused_rdata;
    assign unused_rdata = ^rf_rdata_i;
    assign rf_raddr_o   = 5'd0;
    assign verify_err_o = 1'b0;
`endif

    core_write_while_busy: assert property (
        @(posedge clk_i) disable iff (rst_i) wipe_busy_o |-> !core_we_i
    );

endmodule

// File: tb/tb_ibex_rf_wipe_ctrl.sv
// Directed bench for ibex_rf_wipe_ctrl: a 32-entry instance (no dummy) and a 16-entry instance
// with dummy R0, each with its own register-file model.
module tb_ibex_rf_wipe_ctrl;

  localparam logic [31:0] PRE = 32'hA5A5_A5A5;
`ifdef IBEX_RF_WIPE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req, sel_b, fault_en;
  logic        core_we;
  logic [4:0]  core_waddr;
  logic [31:0] core_wdata;

  logic        req_a, ack_a, busy_a, done_a, stall_a, we_a, dummy_a, err_a;
  logic [4:0]  waddr_a, raddr_a;
  logic [31:0] wdata_a, rdata_a;
  logic        req_b, ack_b, busy_b, done_b, stall_b, we_b, dummy_b, err_b;
  logic [4:0]  waddr_b, raddr_b;
  logic [31:0] wdata_b, rdata_b;

  logic [31:0] rf_a [32];
  logic [31:0] rf_b [32];

  assign req_a = req & ~sel_b;
  assign req_b = req & sel_b;

  ibex_rf_wipe_ctrl #(.RV32E(1'b0), .DataWidth(32), .DummyInstructions(1'b0), .WipeVal(32'h0)) dut_a (
    .clk_i(clk), .rst_i(rst), .wipe_req_i(req_a), .wipe_ack_o(ack_a), .wipe_busy_o(busy_a),
    .wipe_done_o(done_a), .core_stall_o(stall_a), .core_we_i(core_we), .core_waddr_i(core_waddr),
    .core_wdata_i(core_wdata), .rf_we_o(we_a), .rf_waddr_o(waddr_a), .rf_wdata_o(wdata_a),
    .rf_dummy_wb_o(dummy_a), .rf_raddr_o(raddr_a), .rf_rdata_i(rdata_a), .verify_err_o(err_a)
  );

  ibex_rf_wipe_ctrl #(.RV32E(1'b1), .DataWidth(32), .DummyInstructions(1'b1), .WipeVal(32'h0)) dut_b (
    .clk_i(clk), .rst_i(rst), .wipe_req_i(req_b), .wipe_ack_o(ack_b), .wipe_busy_o(busy_b),
    .wipe_done_o(done_b), .core_stall_o(stall_b), .core_we_i(core_we), .core_waddr_i(core_waddr),
    .core_wdata_i(core_wdata), .rf_we_o(we_b), .rf_waddr_o(waddr_b), .rf_wdata_o(wdata_b),
    .rf_dummy_wb_o(dummy_b), .rf_raddr_o(raddr_b), .rf_rdata_i(rdata_b), .verify_err_o(err_b)
  );

  // register-file models
  always @(posedge clk) begin
    if (we_a) rf_a[waddr_a] <= wdata_a;
    if (we_b) rf_b[waddr_b] <= wdata_b;
  end
  assign rdata_a = (fault_en && raddr_a == 5'd7) ? 32'h1 : rf_a[raddr_a];
  assign rdata_b = rf_b[raddr_b];

  // view of the instance under test
  logic        v_ack, v_busy, v_done, v_stall, v_we, v_dummy, v_err;
  logic [4:0]  v_waddr, v_raddr;
  logic [31:0] v_wdata;
  assign v_ack   = sel_b ? ack_b   : ack_a;
  assign v_busy  = sel_b ? busy_b  : busy_a;
  assign v_done  = sel_b ? done_b  : done_a;
  assign v_stall = sel_b ? stall_b : stall_a;
  assign v_we    = sel_b ? we_b    : we_a;
  assign v_dummy = sel_b ? dummy_b : dummy_a;
  assign v_err   = sel_b ? err_b   : err_a;
  assign v_waddr = sel_b ? waddr_b : waddr_a;
  assign v_raddr = sel_b ? raddr_b : raddr_a;
  assign v_wdata = sel_b ? wdata_b : wdata_a;

  // scoreboard
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic preload();
    for (int a = 0; a < 32; a++) begin
      @(posedge clk); #1;
      core_we = 1'b1; core_waddr = 5'(a); core_wdata = PRE;
    end
    @(posedge clk); #1;
    core_we = 1'b0;
  endtask

  task automatic run_wipe(input bit use_b, input bit core_wr, input bit exp_err, input bit hold_req);
    int nw, first, w;
    bit seen;
    logic [31:0] ea;
    logic [31:0] exp_q[$];
    nw    = use_b ? 16 : 32;
    first = use_b ? 0 : 1;
    w     = nw - first;
    for (int a = first; a < nw; a++) exp_q.push_back(32'(a));
    @(posedge clk); #1;
    sel_b = use_b;
    req   = 1'b1;
    if (core_wr) begin
      core_we = 1'b1; core_waddr = 5'd5; core_wdata = 32'h1234;
    end
    @(negedge clk);
    check_val("ack_c0", 32'(v_ack), 1);
    check_val("busy_c0", 32'(v_busy), 0);
    if (core_wr) check_val("pass_c0_addr", 32'(v_waddr), 5);
    @(posedge clk); #1;
    if (!hold_req) req = 1'b0;
    core_we = 1'b0;
    for (int k = 1; k <= w; k++) begin
      @(negedge clk);
      ea = exp_q.pop_front();
      check_val($sformatf("wr_addr_c%0d", k), 32'(v_waddr), ea);
      check_val($sformatf("wr_we_c%0d", k), 32'(v_we), 1);
      check_val($sformatf("wr_data_c%0d", k), v_wdata, 32'h0);
      check_val($sformatf("wr_dummy_c%0d", k), 32'(v_dummy), (ea == 0) ? 1 : 0);
      check_val($sformatf("wr_stall_c%0d", k), 32'(v_stall), 1);
      check_val($sformatf("wr_ack_c%0d", k), 32'(v_ack), 0);
      if (k == 1) check_val("err_cleared", 32'(v_err), 0);
      if (core_wr && k == 1) check_val("x5_core_write", rf_a[5], 32'h1234);
      if (core_wr && k == 6) check_val("x5_wiped", rf_a[5], 32'h0);
    end
    if (VERIFY) begin
      for (int k = 1; k < nw; k++) begin
        @(negedge clk);
        check_val($sformatf("rd_addr_c%0d", w + k), 32'(v_raddr), 32'(k));
        check_val($sformatf("rd_we_c%0d", w + k), 32'(v_we), 0);
        check_val($sformatf("rd_busy_c%0d", w + k), 32'(v_busy), 1);
        check_val($sformatf("rd_err_c%0d", w + k), 32'(v_err), (exp_err && k >= 7) ? 1 : 0);
      end
    end
    @(negedge clk);
    check_val("done_pulse", 32'(v_done), 1);
    check_val("done_busy", 32'(v_busy), 0);
    check_val("done_stall", 32'(v_stall), 0);
    check_val("done_err", 32'(v_err), (VERIFY && exp_err) ? 1 : 0);
    if (hold_req) check_val("done_ack", 32'(v_ack), 0);
    @(negedge clk);
    check_val("done_gone", 32'(v_done), 0);
    if (hold_req) begin
      check_val("reaccept_ack", 32'(v_ack), 1);
      @(posedge clk); #1;
      req  = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
        @(negedge clk);
        if (v_done) seen = 1'b1;
      end
      check_val("reaccept_done", 32'(seen), 1);
    end
  endtask

  task automatic check_regs_a(input string tag, input int lo, input int hi, input logic [31:0] exp);
    int bad;
    bad = 0;
    for (int a = lo; a <= hi; a++) if (rf_a[a] !== exp) bad++;
    check_val(tag, 32'(bad), 0);
  endtask

  initial begin
    int bad;
    bit seen;
    rst = 1'b1; req = 1'b0; sel_b = 1'b0; fault_en = 1'b0;
    core_we = 1'b1; core_waddr = 5'd3; core_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_val("rst_busy", 32'(busy_a), 0);
    check_val("rst_stall", 32'(stall_a), 0);
    check_val("rst_done", 32'(done_a), 0);
    check_val("rst_err", 32'(err_a), 0);
    check_val("rst_raddr", 32'(raddr_a), 0);
    check_val("rst_dummy", 32'(dummy_a), 0);
    check_val("rst_ack", 32'(ack_a), 0);
    check_val("rst_pass_we", 32'(we_a), 1);
    check_val("rst_pass_addr", 32'(waddr_a), 3);
    check_val("rst_pass_data", wdata_a, 32'hDEAD_BEEF);
    check_val("rst_busy_b", 32'(busy_b), 0);
    @(posedge clk); #1;
    core_we = 1'b0;
    rst = 1'b0;

    // full wipe of the 32-entry file
    preload();
    run_wipe(1'b0, 1'b0, 1'b0, 1'b0);
    check_regs_a("a_wiped_x1_x31", 1, 31, 32'h0);
    check_val("a_x0_untouched", rf_a[0], PRE);

    if (VERIFY) begin
      preload();
      fault_en = 1'b1;
      run_wipe(1'b0, 1'b0, 1'b1, 1'b0);
      fault_en = 1'b0;
    end

    // core write in the ack cycle, then overwritten by the wipe
    run_wipe(1'b0, 1'b1, 1'b0, 1'b0);

    // RV32E with dummy R0, request held across done
    preload();
    run_wipe(1'b1, 1'b0, 1'b0, 1'b1);
    bad = 0;
    for (int a = 0; a < 16; a++) if (rf_b[a] !== 32'h0) bad++;
    check_val("b_wiped_x0_x15", 32'(bad), 0);
    sel_b = 1'b0;

    // reset in cycle 10 of a wipe
    preload();
    @(posedge clk); #1;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int c = 1; c < 10; c++) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_busy", 32'(busy_a), 0);
    check_val("abort_stall", 32'(stall_a), 0);
    check_val("abort_we", 32'(we_a), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_a) seen = 1'b1;
    end
    check_val("abort_no_done", 32'(seen), 0);
    check_regs_a("abort_x1_x9_zero", 1, 9, 32'h0);
    check_regs_a("abort_x10_x31_kept", 10, 31, PRE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
